serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Parallel-to-serial framer placed directly upstream of the 1101 sequence-detector FSM.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on data_out, which drives the detector's serial data input.
- Optionally inserts GAP idle cycles between frames.
- Reports bit_valid, busy and a frame_done pulse for the test harness and downstream logic.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- GAP, 0, idle cycles inserted after each frame; legal range 0..15.
- IDLE_LEVEL, 0, value driven on data_out when no frame bit is being sent.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial bit stream to the sequence detector.
- bit_valid  output  1  data_out carries a frame bit.
- busy  output  1  state is not IDLE.
- frame_done  output  1  high during the cycle the last bit of a frame is on data_out.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, shift register = 0, bit counter = 0, gap counter = 0.
  - data_out = IDLE_LEVEL, bit_valid = 0, frame_done = 0, busy = 0.
  - load_ready = 1 as soon as reset is released.
- Reset mid-frame aborts the frame immediately. No partial bits follow, and the in-flight word is discarded.
- Handshake:
  - A transfer occurs on a rising edge where load_valid && load_ready.
  - load_data is sampled only on that edge.
  - load_valid may be held high without a transfer; no word is lost or duplicated.
- load_ready is combinational from state only:
  - It is 1 in IDLE.
  - It is also 1 in SHIFT on the last bit when GAP == 0, which allows back-to-back streaming.
  - It is 0 at all other times.
  - load_ready never depends on load_valid.
- States:
  - IDLE → SHIFT on a transfer.
  - SHIFT → SHIFT after the last bit if GAP == 0 and a transfer occurs (seamless next frame, no idle bit).
  - SHIFT → IDLE after the last bit if GAP == 0 and no transfer occurs.
  - SHIFT → GAP after the last bit if GAP > 0.
  - GAP → IDLE after exactly GAP cycles.
- Latency and output timing:
  - data_out, bit_valid and frame_done are registered.
  - Frame bit 0 in transmit order appears on data_out in the cycle after the accepting edge.
  - The remaining bits follow on consecutive cycles, so a frame occupies exactly WIDTH cycles of bit_valid = 1.
  - frame_done = 1 only with the WIDTH-th bit.
- Bit order:
  - MSB_FIRST = 1: load_data[WIDTH-1] first, down to load_data[0].
  - MSB_FIRST = 0: the reverse order.
- Bit counter: width $clog2(WIDTH), counts 0..WIDTH-1 and wraps to 0 on reload. No overflow is permitted.
- In the GAP and IDLE states: data_out = IDLE_LEVEL and bit_valid = 0.
- busy = 1 in SHIFT and GAP.
- Simultaneous reload on the last bit (GAP == 0): the new word's first bit follows the old word's last bit on the next cycle. frame_done pulses once per frame.

Test Plan:
- WIDTH=4, MSB_FIRST=1, GAP=0: load 4'b1101 at cycle 0 → data_out 1,1,0,1 on cycles 1-4; bit_valid high on cycles 1-4; frame_done high on cycle 4 only; downstream detector asserts seq_detected on cycle 5.
- WIDTH=8, MSB_FIRST=0: load 8'hB4 → data_out 0,0,1,0,1,1,0,1 on cycles 1-8; busy low and load_ready high again on cycle 9.
- Back-to-back, GAP=0, WIDTH=4: load_valid held high with 4'hA then 4'h5 → 1,0,1,0,0,1,0,1 on cycles 1-8 with no idle bit; exactly two frame_done pulses (cycles 4 and 8).
- GAP=2, WIDTH=4, IDLE_LEVEL=1: load 4'h0 twice → four 0 bits, then 2 cycles with data_out=1 and bit_valid=0; load_ready stays low during GAP; second frame starts 1 cycle after load_ready returns.
- Reset mid-frame: assert rst_n low asynchronously during bit 3 of 8'hFF → data_out=IDLE_LEVEL, bit_valid=0 and busy=0 immediately, without waiting for a clock edge; no further frame bits after release; load_ready=1.
- Backpressure: pulse load_valid while busy (GAP=0, not last bit) → word ignored; no transfer occurs, and the current frame completes unchanged.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Parallel-to-serial framer feeding the 1101 sequence-detector FSM. A WIDTH-bit
// word is accepted over a valid/ready handshake and shifted out one bit per
// clock on data_out. The order is MSB-first or LSB-first. GAP idle cycles may
// optionally follow each frame.
//
// Parameters:
//   WIDTH      - bits per frame (2..32)
//   MSB_FIRST  - 1: send load_data[WIDTH-1] first, 0: send load_data[0] first
//   GAP        - idle cycles inserted after each frame (0..15)
//   IDLE_LEVEL - level driven on data_out when no frame bit is being sent
//
// Ports:
//   clk        - clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   load_valid - load_data is valid this cycle
//   load_data  - word to serialize (sampled only on an accepting edge)
//   load_ready - block can accept a word this cycle (depends on state only)
//   data_out   - serial bit stream (registered)
//   bit_valid  - data_out carries a frame bit (registered)
//   busy       - state is SHIFT or GAP
//   frame_done - high while the last bit of a frame is on data_out (registered)
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    // For GAP == 0 this value is never compared against: the GAP state is unreachable.
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // State and datapath registers.
    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;      // bits still to be sent, next one at the head
    logic [CNT_W-1:0] r_bit_cnt;    // index of the bit currently on data_out
    logic [3:0]       r_gap_cnt;
    logic             r_data_out;
    logic             r_bit_valid;
    logic             r_frame_done;

    // Next-state values.
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             w_data_nxt;
    logic             w_valid_nxt;
    logic             w_done_nxt;

    logic             w_last_bit;
    logic             w_load_ready;
    logic             w_xfer;

    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_CNT);

    // Ready comes from state only. It is also high on the last bit when GAP == 0,
    // so the next word can follow with no idle bit between frames.
    assign w_load_ready = (r_state == ST_IDLE) || (w_last_bit && (GAP == 0));
    assign w_xfer       = load_valid && w_load_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_data_nxt    = IDLE_LEVEL;
        w_valid_nxt   = 1'b0;
        w_done_nxt    = 1'b0;

        if (w_xfer) begin
            // Accept: the first bit goes straight to the output register, and the rest
            // are queued in the shift register. This covers IDLE and the seamless reload
            // on the last bit.
            w_state_nxt   = ST_SHIFT;
            w_bit_cnt_nxt = '0;
            w_valid_nxt   = 1'b1;
            if (MSB_FIRST) begin
                w_data_nxt  = load_data[WIDTH-1];
                w_shreg_nxt = load_data << 1;
            end else begin
                w_data_nxt  = load_data[0];
                w_shreg_nxt = load_data >> 1;
            end
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (!w_last_bit) begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                        w_valid_nxt   = 1'b1;
                        w_done_nxt    = (w_bit_cnt_nxt == LAST_CNT);
                        if (MSB_FIRST) begin
                            w_data_nxt  = r_shreg[WIDTH-1];
                            w_shreg_nxt = r_shreg << 1;
                        end else begin
                            w_data_nxt  = r_shreg[0];
                            w_shreg_nxt = r_shreg >> 1;
                        end
                    end else if (GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values and the evaluation order cannot matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_data_out   <= IDLE_LEVEL;
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_data_out   <= w_data_nxt;
            r_bit_valid  <= w_valid_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    assign load_ready = w_load_ready;
    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
//
// Self-checking bench for serial_pattern_tx. There are three instances:
//   u0: WIDTH=4, MSB_FIRST=1, GAP=0, IDLE_LEVEL=0
//   u1: WIDTH=8, MSB_FIRST=0, GAP=0, IDLE_LEVEL=0
//   u2: WIDTH=4, MSB_FIRST=1, GAP=2, IDLE_LEVEL=1
// When a word is offered that will be accepted, its expected bits are pushed to
// a per-instance queue. A monitor on the falling edge pops one entry for every
// cycle with bit_valid high. It checks data_out and frame_done against that
// entry. On every other cycle it checks for the idle level.
// -----------------------------------------------------------------------------
module tb_serial_pattern_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_bit_t;

    logic clk;
    logic rst_n;

    logic       lv0, rdy0, do0, bv0, busy0, fd0;
    logic [3:0] ld0;
    logic       lv1, rdy1, do1, bv1, busy1, fd1;
    logic [7:0] ld1;
    logic       lv2, rdy2, do2, bv2, busy2, fd2;
    logic [3:0] ld2;

    exp_bit_t q0[$];
    exp_bit_t q1[$];
    exp_bit_t q2[$];

    int n_tests = 0;
    int n_fail  = 0;

    serial_pattern_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_data(ld0), .load_ready(rdy0),
        .data_out(do0), .bit_valid(bv0), .busy(busy0), .frame_done(fd0));

    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_data(ld1), .load_ready(rdy1),
        .data_out(do1), .bit_valid(bv1), .busy(busy1), .frame_done(fd1));

    serial_pattern_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2), .IDLE_LEVEL(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_data(ld2), .load_ready(rdy2),
        .data_out(do2), .bit_valid(bv2), .busy(busy2), .frame_done(fd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Inputs are driven and outputs
    // sampled at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transmit order for a 4-bit MSB-first word.
    task automatic push_u0(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q0.push_back('{b: w[i], last: (i == 0)});
    endtask

    task automatic push_u2(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q2.push_back('{b: w[i], last: (i == 0)});
    endtask

    // Expected transmit order for an 8-bit LSB-first word.
    task automatic push_u1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q1.push_back('{b: w[i], last: (i == 7)});
    endtask

    // Scoreboard monitors.
    always @(negedge clk) begin
        exp_bit_t e;
        if (rst_n) begin
            if (bv0) begin
                if (q0.size() == 0) check("u0_unexpected_bit", bv0, 1'b0);
                else begin
                    e = q0.pop_front();
                    check("u0_bit", do0, e.b);
                    check("u0_frame_done", fd0, e.last);
                end
            end else begin
                check("u0_idle_level", do0, 1'b0);
                check("u0_idle_done", fd0, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_bit_t e;
        if (rst_n) begin
            if (bv1) begin
                if (q1.size() == 0) check("u1_unexpected_bit", bv1, 1'b0);
                else begin
                    e = q1.pop_front();
                    check("u1_bit", do1, e.b);
                    check("u1_frame_done", fd1, e.last);
                end
            end else begin
                check("u1_idle_level", do1, 1'b0);
                check("u1_idle_done", fd1, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_bit_t e;
        if (rst_n) begin
            if (bv2) begin
                if (q2.size() == 0) check("u2_unexpected_bit", bv2, 1'b0);
                else begin
                    e = q2.pop_front();
                    check("u2_bit", do2, e.b);
                    check("u2_frame_done", fd2, e.last);
                end
            end else begin
                check("u2_idle_level", do2, 1'b1);
                check("u2_idle_done", fd2, 1'b0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        lv0 = 1'b0; ld0 = '0;
        lv1 = 1'b0; ld1 = '0;
        lv2 = 1'b0; ld2 = '0;

        // ---- Reset state ----
        #12;
        check("rst_bit_valid0", bv0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_data_out0", do0, 1'b0);
        check("rst_frame_done0", fd0, 1'b0);
        check("rst_data_out2", do2, 1'b1);
        check("rst_busy2", busy2, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready0", rdy0, 1'b1);
        check("post_rst_ready1", rdy1, 1'b1);
        check("post_rst_ready2", rdy2, 1'b1);

        // ---- u0: single frame 4'b1101, MSB first ----
        lv0 = 1'b1; ld0 = 4'b1101; push_u0(4'b1101);
        tick();                                   // cycle 1
        lv0 = 1'b0;
        check("t1_c1_bit_valid", bv0, 1'b1);
        check("t1_c1_busy", busy0, 1'b1);
        check("t1_c1_ready", rdy0, 1'b0);
        tick(); tick(); tick();                   // cycle 4 (last bit)
        check("t1_c4_ready_last", rdy0, 1'b1);
        tick();                                   // cycle 5
        check("t1_c5_bit_valid", bv0, 1'b0);
        check("t1_c5_busy", busy0, 1'b0);
        check("t1_c5_ready", rdy0, 1'b1);

        // ---- u0: back-to-back 4'hA then 4'h5, load_valid held ----
        tick();
        lv0 = 1'b1; ld0 = 4'hA; push_u0(4'hA);
        tick();                                   // cycle 1
        ld0 = 4'h5; push_u0(4'h5);
        check("b2b_c1_ready", rdy0, 1'b0);
        tick(); tick();                           // cycle 3
        check("b2b_c3_ready", rdy0, 1'b0);
        tick();                                   // cycle 4
        check("b2b_c4_ready", rdy0, 1'b1);
        check("b2b_c4_done", fd0, 1'b1);
        tick();                                   // cycle 5: second frame, no idle bit
        lv0 = 1'b0;
        check("b2b_c5_bit_valid", bv0, 1'b1);
        check("b2b_c5_ready", rdy0, 1'b0);
        check("b2b_c5_done", fd0, 1'b0);
        tick(); tick(); tick();                   // cycle 8
        check("b2b_c8_done", fd0, 1'b1);
        tick();                                   // cycle 9
        check("b2b_c9_busy", busy0, 1'b0);

        // ---- u0: backpressure, word offered mid-frame is ignored ----
        tick();
        lv0 = 1'b1; ld0 = 4'h6; push_u0(4'h6);
        tick();                                   // cycle 1
        lv0 = 1'b0;
        tick();                                   // cycle 2
        check("bp_c2_ready", rdy0, 1'b0);
        lv0 = 1'b1; ld0 = 4'hF;                   // not accepted, not pushed
        tick();                                   // cycle 3
        lv0 = 1'b0;
        check("bp_c3_busy", busy0, 1'b1);
        tick(); tick();                           // cycle 5
        check("bp_c5_bit_valid", bv0, 1'b0);
        check("bp_c5_busy", busy0, 1'b0);
        tick();
        check("bp_c6_bit_valid", bv0, 1'b0);

        // ---- u1: 8'hB4, LSB first ----
        lv1 = 1'b1; ld1 = 8'hB4; push_u1(8'hB4);
        tick();                                   // cycle 1
        lv1 = 1'b0;
        check("lsb_c1_busy", busy1, 1'b1);
        check("lsb_c1_ready", rdy1, 1'b0);
        for (int i = 2; i <= 8; i++) tick();      // cycle 8
        check("lsb_c8_ready", rdy1, 1'b1);
        check("lsb_c8_done", fd1, 1'b1);
        tick();                                   // cycle 9
        check("lsb_c9_busy", busy1, 1'b0);
        check("lsb_c9_ready", rdy1, 1'b1);
        check("lsb_c9_bit_valid", bv1, 1'b0);

        // ---- u2: GAP=2, IDLE_LEVEL=1, 4'h0 offered twice ----
        tick();
        lv2 = 1'b1; ld2 = 4'h0; push_u2(4'h0); push_u2(4'h0);
        tick();                                   // cycle 1
        check("gap_c1_ready", rdy2, 1'b0);
        tick(); tick(); tick();                   // cycle 4 (last bit)
        check("gap_c4_ready", rdy2, 1'b0);
        tick();                                   // cycle 5: gap
        check("gap_c5_bit_valid", bv2, 1'b0);
        check("gap_c5_data_out", do2, 1'b1);
        check("gap_c5_busy", busy2, 1'b1);
        check("gap_c5_ready", rdy2, 1'b0);
        tick();                                   // cycle 6: gap
        check("gap_c6_ready", rdy2, 1'b0);
        check("gap_c6_busy", busy2, 1'b1);
        tick();                                   // cycle 7: idle, accepts
        check("gap_c7_ready", rdy2, 1'b1);
        check("gap_c7_busy", busy2, 1'b0);
        tick();                                   // cycle 8: second frame bit 0
        lv2 = 1'b0;
        check("gap_c8_bit_valid", bv2, 1'b1);
        for (int i = 9; i <= 13; i++) tick();     // cycle 13: second gap
        check("gap_c13_busy", busy2, 1'b1);
        tick();                                   // cycle 14
        check("gap_c14_busy", busy2, 1'b0);
        check("gap_c14_ready", rdy2, 1'b1);

        // ---- u1: asynchronous reset during bit 3 of 8'hFF ----
        tick();
        lv1 = 1'b1; ld1 = 8'hFF; push_u1(8'hFF);
        tick();                                   // cycle 1
        lv1 = 1'b0;
        tick(); tick();                           // cycle 3
        check("ar_c3_bit_valid", bv1, 1'b1);
        #2 rst_n = 1'b0;                          // between edges
        #1;
        check("ar_data_out", do1, 1'b0);
        check("ar_bit_valid", bv1, 1'b0);
        check("ar_busy", busy1, 1'b0);
        check("ar_frame_done", fd1, 1'b0);
        q1.delete();                              // the in-flight word is discarded
        #3 rst_n = 1'b1;
        tick();
        check("ar_ready", rdy1, 1'b1);
        check("ar_post_bit_valid", bv1, 1'b0);
        for (int i = 0; i < 8; i++) tick();       // monitor flags any leftover bit
        check("ar_post_busy", busy1, 1'b0);

        // Every scheduled bit must have been produced.
        tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
